// File: rtl/proc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// proc_fetch_unit_pkg : shared types and constants for the TinyRV1 fetch stage
// Revision 1.0
// ============================================================================
package proc_fetch_unit_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0200;
  localparam logic [31:0] C_PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } f2d_entry_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + C_PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_fetch_unit_queue.sv
`default_nettype none
// ============================================================================
// proc_fetch_unit_queue : circular FIFO buffering fetched {inst, pc} entries
// Revision 1.0
// ============================================================================
module proc_fetch_unit_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enq,
  input  logic                       i_deq,
  input  logic                       i_clear,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [IW-1:0] r_wr;
  logic [IW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_enq;
  logic          w_do_deq;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] p);
    return (p == IW'(DEPTH-1)) ? '0 : p + IW'(1);
  endfunction

  // Clear discards both the stored entries and any enqueue in the same cycle.
  assign w_do_enq = i_enq & ~i_clear;
  assign w_do_deq = i_deq & ~i_clear & (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) r_wr <= bump(r_wr);
      if (w_do_deq) r_rd <= bump(r_rd);
      r_count <= r_count + CW'(w_do_enq) - CW'(w_do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/proc_fetch_unit.sv
`default_nettype none
// ============================================================================
// proc_fetch_unit : TinyRV1 F stage - PC, credit-limited imem requests,
//                   in-order response queue, redirect with stale-drop counting
// Revision 1.0
// ============================================================================
module proc_fetch_unit
  import proc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imemreq_val,
  input  logic        i_imemreq_rdy,
  output logic [31:0] o_imemreq_addr,
  input  logic        i_imemresp_val,
  input  logic [31:0] i_imemresp_data,
  input  logic        i_redirect_val,
  input  logic [31:0] i_redirect_target,
  output logic        o_f2d_val,
  output logic [31:0] o_f2d_inst,
  output logic [31:0] o_f2d_pc,
  input  logic        i_d2f_rdy
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_pc_f;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;

  logic          w_deq;
  logic          w_fire;
  logic          w_stale;
  logic          w_enq;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_occ_after;
  logic [CW:0]   w_credit_sum;
  f2d_entry_t    w_enq_entry;
  f2d_entry_t    w_head;

  assign w_deq       = o_f2d_val & i_d2f_rdy;
  assign w_occ_after = i_redirect_val ? '0 : (w_occ - CW'(w_deq));
  // A request is only issued when a queue slot is guaranteed for its response.
  assign w_credit_sum   = {1'b0, r_live} + {1'b0, w_occ_after};
  assign o_imemreq_val  = ~rst & (w_credit_sum < (CW+1)'(DEPTH));
  assign o_imemreq_addr = i_redirect_val ? i_redirect_target : r_pc_f;
  assign w_fire         = o_imemreq_val & i_imemreq_rdy;

  assign w_stale = i_imemresp_val & (i_redirect_val | (r_drop != '0));
  assign w_enq   = i_imemresp_val & ~w_stale;

  assign w_enq_entry.inst = i_imemresp_data;
  assign w_enq_entry.pc   = r_resp_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f    <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_live    <= '0;
      r_drop    <= '0;
    end else begin
      if (w_fire)              r_pc_f <= pc_incr(o_imemreq_addr);
      else if (i_redirect_val) r_pc_f <= i_redirect_target;

      if (i_redirect_val) begin
        // Everything still in flight, minus this cycle's arrival, becomes stale.
        r_resp_pc <= i_redirect_target;
        r_live    <= CW'(w_fire);
        r_drop    <= r_drop + r_live - CW'(i_imemresp_val);
      end else begin
        if (w_enq) r_resp_pc <= pc_incr(r_resp_pc);
        r_live <= r_live + CW'(w_fire) - CW'(w_enq);
        if (w_stale) r_drop <= r_drop - CW'(1);
      end
    end
  end

  proc_fetch_unit_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(f2d_entry_t))
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_enq   (w_enq),
    .i_deq   (w_deq),
    .i_clear (i_redirect_val),
    .i_data  (w_enq_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  assign o_f2d_val  = ~rst & ~w_empty & ~i_redirect_val;
  assign o_f2d_inst = w_head.inst;
  assign o_f2d_pc   = w_head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_enq && w_full));

  a_no_drop_underflow: assert property (@(posedge clk) disable iff (rst)
    !(i_redirect_val && (({1'b0, r_drop} + {1'b0, r_live}) < (CW+1)'(i_imemresp_val))));

endmodule
`default_nettype wire
